// File: rtl/rr_mux_arb.sv
// rr_mux_arb: NCH-input, WIDTH-bit registered multiplexer with per-channel
// valid/ready handshakes. Channel selection is either fixed (external sel)
// or round-robin. The output is a one-deep register stage: 1-cycle latency,
// full throughput.
module rr_mux_arb #(
  parameter int NCH   = 4,
  parameter int WIDTH = 8,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [SELW-1:0]  r_ch;
  logic [SELW-1:0]  r_ptr;

  logic             w_load_en;
  logic             w_sel_ok;
  logic             w_fix_hit;
  logic             w_rr_hit;
  logic [SELW-1:0]  w_rr_idx;
  logic             w_gnt_hit;
  logic [SELW-1:0]  w_gnt_idx;
  logic [NCH-1:0]   w_grant;
  logic [SELW-1:0]  w_ptr_nxt;

  // The register can take a new word when empty or being drained this cycle.
  assign w_load_en = !r_valid | out_ready;

  // sel can only point past the last channel when NCH is not a power of two.
  generate
    if (NCH == (1 << SELW)) begin : g_sel_full
      assign w_sel_ok = 1'b1;
    end else begin : g_sel_part
      assign w_sel_ok = (sel < SELW'(NCH));
    end
  endgenerate

  assign w_fix_hit = w_sel_ok & in_valid[sel];

  // Round-robin scan starting at the pointer; walking k downward leaves the
  // closest valid channel (smallest offset from ptr) as the final winner.
  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_idx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      int j;
      j = (int'(r_ptr) + k) % NCH;
      if (in_valid[j]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = SELW'(j);
      end
    end
  end

  assign w_gnt_hit = mode ? w_rr_hit : w_fix_hit;
  assign w_gnt_idx = mode ? w_rr_idx : sel;

  // One-hot grant vector, qualified by load_en to form in_ready.
  always_comb begin
    w_grant = '0;
    if (w_gnt_hit) w_grant[w_gnt_idx] = 1'b1;
  end

  assign in_ready = w_load_en ? w_grant : '0;

  // Pointer advances past the granted channel, wrapping NCH-1 -> 0.
  assign w_ptr_nxt = (w_gnt_idx == SELW'(NCH - 1)) ? '0 : w_gnt_idx + 1'b1;

  // Output register stage: load on grant, empty on no grant, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ch    <= '0;
    end else if (w_load_en) begin
      if (w_gnt_hit) begin
        r_data  <= in_data[w_gnt_idx*WIDTH +: WIDTH];
        r_ch    <= w_gnt_idx;
        r_valid <= 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  // Round-robin pointer moves only on an actual transfer in round-robin mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (mode && w_load_en && w_gnt_hit) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_ch    = r_ch;

endmodule

// File: doc/rr_mux_arb.md
Name: rr_mux_arb

Overview:
- Parametrised successor to the team's 2:1 combinational mux: an NCH-input, WIDTH-bit registered multiplexer.
- Per-channel valid/ready handshakes.
- Two select modes: fixed (external sel, like the plain mux) and round-robin arbitration.
- Sits between multiple producers and a single consumer. The output is a one-deep register stage, so the consumer sees 1-cycle latency and full throughput.

Parameters:
- NCH, 4, number of input channels (>= 2)
- WIDTH, 8, data width per channel
- SELW, $clog2(NCH), width of sel and out_ch (derived; do not override)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NCH  channel i has data
- in_ready  output  NCH  channel i transfer accepted this cycle
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SELW  channel index used when mode=0
- out_data  output  WIDTH  registered selected data
- out_valid  output  1  out_data holds an unconsumed word
- out_ready  input  1  consumer accepts out_data
- out_ch  output  SELW  index of the channel that produced out_data

Behaviour:
- Reset (async assert, sync release on clk): out_valid=0, out_data=0, out_ch=0, rr pointer=0. in_ready is combinational and therefore 0 while out_valid=0 and no input is valid.
- load_en = !out_valid | out_ready. This gives full throughput with no bubble when the consumer is always ready.
- Arbitration is combinational each cycle. It produces a one-hot grant (or no grant):
  - mode=0: grant sel if in_valid[sel]=1, else none. If sel >= NCH (only possible when NCH is not a power of two), no grant.
  - mode=1: scan channels ptr, ptr+1, ..., wrapping mod NCH. Grant the first with in_valid=1. No grant if all are idle.
- in_ready[i] = load_en & grant[i]. At most one bit is set. An input transfer occurs when in_valid[i] & in_ready[i].
- On a clk edge with load_en=1:
  - If there is a grant: out_data <= channel data, out_ch <= granted index, out_valid <= 1.
  - If there is no grant: out_valid <= 0; out_data and out_ch hold their last values.
- On a clk edge with load_en=0: out_data, out_ch and out_valid hold. Output is stable while out_valid & !out_ready.
- Latency: a word accepted at edge N is visible on out_data after edge N.
- Round-robin pointer:
  - Updates only on an input transfer in mode=1: ptr <= (granted+1) mod NCH, wrapping NCH-1 -> 0.
  - No transfer: ptr holds.
  - ptr is not modified in mode=0.
- Fairness: in mode=1, with all channels continuously valid and out_ready=1, the grant order is 0,1,...,NCH-1,0,... Each channel waits at most NCH-1 transfers.
- Mode or sel changes take effect on the next arbitration. A word already held in the output register is unaffected.
- Simultaneous output consume and input load in the same cycle: the new word replaces the old one with no gap.
- Reset mid-operation: a pending output word is discarded. out_valid drops immediately (asynchronously). The pointer returns to 0.
- Producers must hold in_data/in_valid stable until their in_ready. The block does not check this.

Test Plan:
1. Reset:
   - Stimulus: drive rst_n=0 mid-stream with out_valid=1.
   - Required: out_valid, out_data, out_ch go to 0 without a clock edge. After release with all in_valid=0, out_valid stays 0.
2. Fixed mode, NCH=4, WIDTH=8:
   - Stimulus: in_data = {8'hD3,8'hC2,8'hB1,8'hA0}, all valid, out_ready=1; sweep sel 0..3, one cycle each.
   - Required: out_data = A0, B1, C2, D3 one cycle after each sel, out_ch = sel, in_ready one-hot matching sel. Then set sel=2 with in_valid[2]=0: in_ready=0 and out_valid=0 next cycle.
3. Round-robin fairness:
   - Stimulus: mode=1, all valid, out_ready=1, 8 cycles.
   - Required: out_ch sequence 0,1,2,3,0,1,2,3, with out_valid=1 every cycle after the first.
4. Round-robin skip and wrap:
   - Stimulus: mode=1, only channels 1 and 3 valid.
   - Required: out_ch alternates 1,3,1,3. After a channel-3 grant the pointer wraps to 0 and channel 1 is next.
5. Backpressure:
   - Stimulus: out_ready=0 for 3 cycles with a word held (out_ch=2, out_data=C2).
   - Required: out_data, out_ch, out_valid stable and in_ready=0 throughout. When out_ready returns to 1 the next word loads the same cycle, no bubble, and the pointer has not advanced during the stall.
6. Mode switch:
   - Stimulus: mode=1 granted channel 1 (ptr=2); switch to mode=0 with sel=0 for 2 cycles, then back to mode=1.
   - Required: out_ch = 0, 0, then 2 (the pointer was preserved through fixed mode).
